// File: rtl/sm_clk_wake_sched.sv
// Per-SM clock-enable scheduler: idle-timeout gating plus round-robin,
// rate-limited wake grants. Optional debug override: SM_CLK_FORCE_ON_EN.
//
// Per-SM state (clk_en[i])
//   state | meaning
//   OFF   | clock gated; activity or wake_pend raises a wake request
//   ON    | clock running; idle counter counts toward IDLE_THRESH
module sm_clk_wake_sched #(
  parameter int NUM_SM      = 4,
  parameter int IDLE_THRESH = 1024,
  parameter int CNT_W       = 16,
  parameter int WAKE_GAP    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_SM-1:0] activity,
`ifdef SM_CLK_FORCE_ON_EN
  input  logic              force_on,
`endif
  output logic [NUM_SM-1:0] clk_en,
  output logic [NUM_SM-1:0] wake_pend
);

  localparam int PTR_W = $clog2(NUM_SM);

  logic [CNT_W-1:0] idle_cnt [NUM_SM];
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;
  logic [7:0]       gap_cnt;
  logic [NUM_SM-1:0] req;
  logic [NUM_SM-1:0] grant;
  logic             grant_any;

  // Only gated SMs compete for a wake slot.
  assign req = ~clk_en & (wake_pend | activity);

  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    idx       = 0;
    idx_p     = '0;
    grant     = '0;
    grant_any = 1'b0;
    rr_next   = rr_ptr;
    if (gap_cnt == 8'd0) begin
      for (int k = 0; k < NUM_SM; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_SM) idx = idx - NUM_SM;
        idx_p = PTR_W'(idx);
        if (!grant_any && req[idx_p]) begin
          grant_any    = 1'b1;
          grant[idx_p] = 1'b1;
          rr_next      = (idx == NUM_SM - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_en    <= '0;
      wake_pend <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= 8'd0;
      for (int i = 0; i < NUM_SM; i++) idle_cnt[i] <= '0;
    end else begin
`ifdef SM_CLK_FORCE_ON_EN
      if (force_on) begin
        clk_en    <= '1;
        wake_pend <= '0;
        gap_cnt   <= 8'd0;
        for (int i = 0; i < NUM_SM; i++) idle_cnt[i] <= '0;
      end else begin
`endif
        for (int i = 0; i < NUM_SM; i++) begin
          if (clk_en[i]) begin
            // Activity beats the threshold check; the counter never wraps.
            if (activity[i])
              idle_cnt[i] <= '0;
            else if (idle_cnt[i] < CNT_W'(IDLE_THRESH))
              idle_cnt[i] <= idle_cnt[i] + 1'b1;
            else
              clk_en[i] <= 1'b0;
          end else if (grant[i]) begin
            clk_en[i]    <= 1'b1;
            idle_cnt[i]  <= '0;
            wake_pend[i] <= 1'b0;
          end else if (req[i]) begin
            wake_pend[i] <= 1'b1;
          end
        end
        if (grant_any) begin
          gap_cnt <= 8'(WAKE_GAP - 1);
          rr_ptr  <= rr_next;
        end else if (gap_cnt != 8'd0) begin
          gap_cnt <= gap_cnt - 8'd1;
        end
`ifdef SM_CLK_FORCE_ON_EN
      end
`endif
    end
  end

endmodule

// File: tb/tb_sm_clk_wake_sched.sv
// Directed bench for sm_clk_wake_sched at default parameters.
// Build with SM_CLK_FORCE_ON_EN defined to also exercise the force_on path.
module tb_sm_clk_wake_sched;

  logic       clk;
  logic       rstn;
  logic [3:0] activity;
  logic [3:0] clk_en;
  logic [3:0] wake_pend;
`ifdef SM_CLK_FORCE_ON_EN
  logic       force_on;
`endif

  int vec_cnt;
  int err_cnt;

  sm_clk_wake_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .activity  (activity),
`ifdef SM_CLK_FORCE_ON_EN
    .force_on  (force_on),
`endif
    .clk_en    (clk_en),
    .wake_pend (wake_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++;
    if (clk_en !== 4'b0000 || wake_pend !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_assert: clk_en=%b wake_pend=%b want 0000/0000", clk_en, wake_pend);
    end
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      vec_cnt++;
      if (clk_en !== 4'b0000 || wake_pend !== 4'b0000) begin
        err_cnt++;
        $display("FAIL reset_idle cyc%0d: clk_en=%b wake_pend=%b want 0000/0000", c, clk_en, wake_pend);
      end
    end
  endtask

  task automatic test_single_wake();
    activity = 4'b0001;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b0001 || wake_pend !== 4'b0000) begin
      err_cnt++;
      $display("FAIL single_wake: clk_en=%b wake_pend=%b want 0001/0000", clk_en, wake_pend);
    end
    for (int c = 1; c <= 1024; c++) tick();
    vec_cnt++;
    if (clk_en !== 4'b0001) begin
      err_cnt++;
      $display("FAIL single_hold_k1024: clk_en=%b want 0001", clk_en);
    end
    tick();
    vec_cnt++;
    if (clk_en !== 4'b0000) begin
      err_cnt++;
      $display("FAIL single_sleep_k1025: clk_en=%b want 0000", clk_en);
    end
  endtask

  task automatic test_staggered();
    logic [3:0] exp_en;
    pulse_reset();
    activity = 4'b1111;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b0001 || wake_pend !== 4'b1110) begin
      err_cnt++;
      $display("FAIL stagger_k: clk_en=%b wake_pend=%b want 0001/1110", clk_en, wake_pend);
    end
    for (int j = 1; j <= 26; j++) begin
      tick();
      exp_en = 4'b0001;
      if (j >= 8)  exp_en = exp_en | 4'b0010;
      if (j >= 16) exp_en = exp_en | 4'b0100;
      if (j >= 24) exp_en = exp_en | 4'b1000;
      vec_cnt++;
      if (clk_en !== exp_en || wake_pend !== ~exp_en) begin
        err_cnt++;
        $display("FAIL stagger_k+%0d: clk_en=%b wake_pend=%b want %b/%b", j, clk_en, wake_pend, exp_en, ~exp_en);
      end
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    activity = 4'b0100;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b0100) begin
      err_cnt++;
      $display("FAIL rr_grant2: clk_en=%b want 0100", clk_en);
    end
    for (int c = 0; c < 7; c++) tick();
    activity = 4'b1001;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b1100 || wake_pend !== 4'b0001) begin
      err_cnt++;
      $display("FAIL rr_first_sm3: clk_en=%b wake_pend=%b want 1100/0001", clk_en, wake_pend);
    end
    for (int c = 1; c <= 7; c++) begin
      tick();
      vec_cnt++;
      if (clk_en !== 4'b1100 || wake_pend !== 4'b0001) begin
        err_cnt++;
        $display("FAIL rr_wait+%0d: clk_en=%b wake_pend=%b want 1100/0001", c, clk_en, wake_pend);
      end
    end
    tick();
    vec_cnt++;
    if (clk_en !== 4'b1101 || wake_pend !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rr_then_sm0: clk_en=%b wake_pend=%b want 1101/0000", clk_en, wake_pend);
    end
  endtask

  task automatic test_threshold_race();
    pulse_reset();
    activity = 4'b0010;
    tick();
    activity = 4'b0000;
    for (int c = 0; c < 1024; c++) tick();
    vec_cnt++;
    if (clk_en !== 4'b0010) begin
      err_cnt++;
      $display("FAIL race_pre: clk_en=%b want 0010", clk_en);
    end
    activity = 4'b0010;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b0010) begin
      err_cnt++;
      $display("FAIL race_edge: clk_en=%b want 0010", clk_en);
    end
    for (int c = 0; c < 1024; c++) tick();
    vec_cnt++;
    if (clk_en !== 4'b0010) begin
      err_cnt++;
      $display("FAIL race_recount_hold: clk_en=%b want 0010", clk_en);
    end
    tick();
    vec_cnt++;
    if (clk_en !== 4'b0000) begin
      err_cnt++;
      $display("FAIL race_recount_sleep: clk_en=%b want 0000", clk_en);
    end
  endtask

  task automatic test_reset_midop();
    pulse_reset();
    activity = 4'b0001;
    tick();
    activity = 4'b0110;
    tick();
    activity = 4'b0000;
    vec_cnt++;
    if (clk_en !== 4'b0001 || wake_pend !== 4'b0110) begin
      err_cnt++;
      $display("FAIL midrst_setup: clk_en=%b wake_pend=%b want 0001/0110", clk_en, wake_pend);
    end
    #2;
    rstn = 1'b0;
    #1;
    vec_cnt++;
    if (clk_en !== 4'b0000 || wake_pend !== 4'b0000) begin
      err_cnt++;
      $display("FAIL midrst_async: clk_en=%b wake_pend=%b want 0000/0000", clk_en, wake_pend);
    end
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      vec_cnt++;
      if (clk_en !== 4'b0000 || wake_pend !== 4'b0000) begin
        err_cnt++;
        $display("FAIL midrst_after cyc%0d: clk_en=%b wake_pend=%b want 0000/0000", c, clk_en, wake_pend);
      end
    end
  endtask

`ifdef SM_CLK_FORCE_ON_EN
  task automatic test_force_on();
    pulse_reset();
    force_on = 1'b1;
    tick();
    vec_cnt++;
    if (clk_en !== 4'b1111 || wake_pend !== 4'b0000) begin
      err_cnt++;
      $display("FAIL force_on_k: clk_en=%b wake_pend=%b want 1111/0000", clk_en, wake_pend);
    end
    for (int c = 0; c < 5; c++) tick();
    force_on = 1'b0;
    for (int c = 0; c < 1024; c++) tick();
    vec_cnt++;
    if (clk_en !== 4'b1111) begin
      err_cnt++;
      $display("FAIL force_release_hold: clk_en=%b want 1111", clk_en);
    end
    tick();
    vec_cnt++;
    if (clk_en !== 4'b0000) begin
      err_cnt++;
      $display("FAIL force_release_sleep: clk_en=%b want 0000", clk_en);
    end
  endtask
`endif

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    rstn     = 1'b0;
    activity = 4'b0000;
`ifdef SM_CLK_FORCE_ON_EN
    force_on = 1'b0;
`endif
    test_reset();
    test_single_wake();
    test_staggered();
    test_round_robin();
    test_threshold_race();
    test_reset_midop();
`ifdef SM_CLK_FORCE_ON_EN
    test_force_on();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sm_clk_wake_sched.md
# sm_clk_wake_sched

Multi-SM clock-enable scheduler that owns the per-SM register clock enables for a cluster of `NUM_SM` streaming multiprocessors. It gates each idle SM after a programmable idle interval. It re-enables SMs on demand, at most one SM every `WAKE_GAP` cycles, which bounds di/dt on the shared rail. Wake requests are granted round-robin. The block sits between the SM issue logic (activity pulses) and the SM clock-gate cells.

## Interface
Parameters:
- `NUM_SM`, 4: number of SMs controlled (2..16).
- `IDLE_THRESH`, 1024: idle cycles before an SM is gated; must be < 2^`CNT_W`.
- `CNT_W`, 16: idle counter width.
- `WAKE_GAP`, 8: minimum cycles between successive wake grants (1..255).

Ports:
- `clk`, input, 1: single clock for all logic.
- `rstn`, input, 1: asynchronous, active-low reset.
- `activity`, input, `NUM_SM`: per-SM pulse or level, high when the SM has work to issue.
- `clk_en`, output, `NUM_SM`: registered clock enable per SM.
- `wake_pend`, output, `NUM_SM`: registered; high while the SM is waiting for a wake grant (issue logic must stall).
- `force_on`, input, 1: present only with `SM_CLK_FORCE_ON_EN`.

## Operation
Each SM has a state of OFF or ON, given by `clk_en[i]`, plus a pending flag and an idle counter.
- **Reset:** `clk_en`=0, `wake_pend`=0, all idle counters 0, `rr_ptr`=0, gap counter 0.
- **ON, `activity[i]`=1:** `idle_cnt[i]`←0; SM stays ON.
- **ON, `activity[i]`=0, `idle_cnt[i]` < `IDLE_THRESH`:** `idle_cnt[i]`←`idle_cnt[i]`+1.
- **ON, `activity[i]`=0, `idle_cnt[i]` ≥ `IDLE_THRESH`:** `clk_en[i]`←0; the counter holds (no wrap).
- **ON, activity in the same cycle the threshold is reached:** activity wins; SM stays ON and the counter clears.
- **OFF, wake request:** the request is `req[i]` = `wake_pend[i]` | `activity[i]` (combinational).
- **Arbiter:** when `gap_cnt`=0 and any `req` is high, grant the first requester at or after `rr_ptr`, scanning upward and wrapping.
- **Granted SM i:** `clk_en[i]`←1, `idle_cnt[i]`←0, `wake_pend[i]`←0, `rr_ptr`←(i+1) mod `NUM_SM`, `gap_cnt`←`WAKE_GAP`-1.
- **Non-granted requesters:** `wake_pend[i]`←1. The flag stays set until granted, even if `activity` drops.
- **Gap counter:** `gap_cnt` decrements to 0 and saturates there. Only one grant per cycle.
- **Sleep does not consume a gap slot:** gating an SM off never touches `gap_cnt`.

## Timing
- **Wake latency, arbiter free:** activity sampled at edge k → `clk_en[i]`=1 after edge k.
- **Wake latency, arbiter busy:** `wake_pend[i]`=1 after edge k; grant at the first edge where `gap_cnt`=0 and i wins.
- **Sleep latency:** last activity at edge k → counter reaches `IDLE_THRESH` at edge k+`IDLE_THRESH` → `clk_en`=0 after edge k+`IDLE_THRESH`+1.
- **Worst-case wake latency:** (`NUM_SM`-1)·`WAKE_GAP` + 1 cycles after request.
- **Reset mid-operation:** asynchronous assertion clears all state immediately, including pending wakes; outputs return to reset values without waiting for `clk`.

## Configuration
- **`SM_CLK_FORCE_ON_EN` defined:** adds the `force_on` input.
  - While `force_on`=1: every `clk_en` is 1 from the next edge, ungated by `WAKE_GAP` (the debug/test path). `wake_pend` clears, idle counters are held at 0, and `gap_cnt` is held at 0.
  - On deassert, all SMs are ON and begin idle counting from 0.
- **`SM_CLK_FORCE_ON_EN` undefined:** the port is absent and behaviour is as described above.

## Test plan
1. **Reset:** assert `rstn`=0 → `clk_en`=0000, `wake_pend`=0000. Release with `activity`=0 for 100 cycles → outputs unchanged.
2. **Single wake and sleep (defaults):** `activity[0]` pulse at edge k → `clk_en[0]`=1 after k. `clk_en[0]` stays 1 through edge k+1024 and is 0 after edge k+1025.
3. **Staggered wake:** `activity`=1111 pulse at edge k, `rr_ptr`=0 → `clk_en[0]` after k, `[1]` after k+8, `[2]` after k+16, `[3]` after k+24. `wake_pend` bits clear in the same order.
4. **Round-robin:** after a grant to SM2, SM0 and SM3 request simultaneously → SM3 is granted first, SM0 `WAKE_GAP` cycles later.
5. **Threshold race:** `activity[1]`=1 on the exact edge where `idle_cnt[1]`=`IDLE_THRESH` → `clk_en[1]` stays 1 and the counter returns to 0. Separately, `rstn` pulsed low while `wake_pend`=0110 → all outputs 0 immediately, no grants after release.
6. **`SM_CLK_FORCE_ON_EN`:** all SMs OFF; `force_on`=1 at edge k → `clk_en`=1111 after k. Deassert at edge m, no activity → all SMs gate after edge m+1025.
